// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the instruction decoder/ALU (master) and the
// program-counter sequencer (slave).
interface pc_sequencer_if #(
    parameter int PC_W  = 10,
    parameter int REL_W = 6
);
    logic                    Start;
    logic                    Halt;
    logic                    Branch;
    logic                    BrRel;
    logic                    Taken;
    logic [PC_W-1:0]         Target;
    logic signed [REL_W-1:0] Offset;
    logic                    Call;
    logic                    Ret;
    logic [PC_W-1:0]         PC;
    logic                    Running;
    logic                    Done;
    logic                    StackErr;

    modport master (
        output Start, Halt, Branch, BrRel, Taken, Target, Offset, Call, Ret,
        input  PC, Running, Done, StackErr
    );

    modport slave (
        input  Start, Halt, Branch, BrRel, Taken, Target, Offset, Call, Ret,
        output PC, Running, Done, StackErr
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALTED control, absolute and
// flag-qualified relative branches, and a hardware return-address stack.
module pc_sequencer #(
    parameter int PC_W        = 10,
    parameter int REL_W       = 6,
    parameter int STACK_DEPTH = 4,
    parameter int START_ADDR  = 0
) (
    input  logic          clk,
    input  logic          Init_n,
    pc_sequencer_if.slave bus
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
    localparam logic [SP_W-1:0] SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_ONE   = SP_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [SP_W-1:0] sp, sp_nxt;
    logic            err, err_nxt;
    logic            running, done;
    logic            push;
    logic [PC_W-1:0] stack [STACK_DEPTH];

    logic [IDX_W-1:0] wr_idx, top_idx;
    logic [PC_W-1:0]  pc_plus1;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] base);
        return base + PC_W'(1);
    endfunction

    // Offset is sign-extended to PC width; the sum wraps modulo 2**PC_W.
    function automatic logic [PC_W-1:0] pc_rel(input logic [PC_W-1:0] base,
                                               input logic signed [REL_W-1:0] off);
        logic signed [PC_W-1:0] ext;
        ext = PC_W'(off);
        return base + ext;
    endfunction

    assign wr_idx   = IDX_W'(sp);
    assign top_idx  = IDX_W'(sp - SP_ONE);
    assign pc_plus1 = pc_inc(pc);

    always_ff @(posedge clk or negedge Init_n) begin
        if (!Init_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        sp_nxt    = sp;
        err_nxt   = err;
        push      = 1'b0;
        unique case (state)
            IDLE, HALTED: begin
                if (bus.Start) begin
                    state_nxt = RUN;
                    pc_nxt    = START_PC;
                    sp_nxt    = '0;
                    err_nxt   = 1'b0;
                end
            end
            RUN: begin
                if (bus.Halt) begin
                    state_nxt = HALTED;
                end else if (bus.Ret) begin
                    if (sp == '0) begin
                        pc_nxt  = pc_plus1;
                        err_nxt = 1'b1;
                    end else begin
                        pc_nxt = stack[top_idx];
                        sp_nxt = sp - SP_ONE;
                    end
                end else if (bus.Call) begin
                    // The jump is taken even when the return address cannot be saved.
                    pc_nxt = bus.Target;
                    if (sp == SP_FULL) begin
                        err_nxt = 1'b1;
                    end else begin
                        push   = 1'b1;
                        sp_nxt = sp + SP_ONE;
                    end
                end else if (bus.Branch) begin
                    if (!bus.BrRel) begin
                        pc_nxt = bus.Target;
                    end else if (bus.Taken) begin
                        pc_nxt = pc_rel(pc, bus.Offset);
                    end else begin
                        pc_nxt = pc_plus1;
                    end
                end else begin
                    pc_nxt = pc_plus1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Init_n) begin
        if (!Init_n) begin
            pc      <= START_PC;
            sp      <= '0;
            err     <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            pc      <= pc_nxt;
            sp      <= sp_nxt;
            err     <= err_nxt;
            running <= (state_nxt == RUN);
            done    <= (state_nxt == HALTED);
        end
    end

    // Entries above sp are don't-care, so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[wr_idx] <= pc_plus1;
        end
    end

    assign bus.PC       = pc;
    assign bus.Running  = running;
    assign bus.Done     = done;
    assign bus.StackErr = err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (PC_W=10, REL_W=6, STACK_DEPTH=4).
module tb_pc_sequencer;

    logic clk;
    logic init_n;
    int   total;
    int   bad;

    pc_sequencer_if #(.PC_W(10), .REL_W(6)) bus ();

    pc_sequencer #(
        .PC_W(10), .REL_W(6), .STACK_DEPTH(4), .START_ADDR(0)
    ) dut (
        .clk    (clk),
        .Init_n (init_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.Start  = 1'b0;
        bus.Halt   = 1'b0;
        bus.Branch = 1'b0;
        bus.BrRel  = 1'b0;
        bus.Taken  = 1'b0;
        bus.Target = '0;
        bus.Offset = '0;
        bus.Call   = 1'b0;
        bus.Ret    = 1'b0;
    endtask

    task automatic test_reset();
        clr();
        init_n = 1'b0;
        step();
        step();
        total++; if (bus.PC !== 10'd0) begin bad++; $display("FAIL reset_pc PC=%0d want=0", bus.PC); end
        total++; if (bus.Running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", bus.Running); end
        total++; if (bus.Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.Done); end
        total++; if (bus.StackErr !== 1'b0) begin bad++; $display("FAIL reset_stackerr got=%b want=0", bus.StackErr); end
        init_n = 1'b1;
        bus.Branch = 1'b1;
        bus.Target = 10'd10;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus.PC !== 10'd0) begin bad++; $display("FAIL idle_pc cyc=%0d PC=%0d want=0", i, bus.PC); end
            total++; if (bus.Running !== 1'b0) begin bad++; $display("FAIL idle_running cyc=%0d got=%b want=0", i, bus.Running); end
        end
        clr();
    endtask

    task automatic test_start_abs();
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        total++; if (bus.PC !== 10'd0) begin bad++; $display("FAIL start_pc PC=%0d want=0", bus.PC); end
        total++; if (bus.Running !== 1'b1) begin bad++; $display("FAIL start_running got=%b want=1", bus.Running); end
        step();
        total++; if (bus.PC !== 10'd1) begin bad++; $display("FAIL first_inc PC=%0d want=1", bus.PC); end
        bus.Branch = 1'b1; bus.Target = 10'd10;
        step();
        clr();
        total++; if (bus.PC !== 10'd10) begin bad++; $display("FAIL abs_branch PC=%0d want=10", bus.PC); end
    endtask

    task automatic test_rel_branch();
        bus.Branch = 1'b1; bus.BrRel = 1'b1; bus.Offset = 6'sd5; bus.Taken = 1'b0;
        step();
        total++; if (bus.PC !== 10'd11) begin bad++; $display("FAIL rel_not_taken PC=%0d want=11", bus.PC); end
        bus.Taken = 1'b1;
        step();
        total++; if (bus.PC !== 10'd16) begin bad++; $display("FAIL rel_taken PC=%0d want=16", bus.PC); end
        bus.Offset = -6'sd16;
        step();
        total++; if (bus.PC !== 10'd0) begin bad++; $display("FAIL rel_negative PC=%0d want=0", bus.PC); end
        clr();
        bus.Branch = 1'b1; bus.Target = 10'd16;
        step();
        clr();
        total++; if (bus.PC !== 10'd16) begin bad++; $display("FAIL abs_to_16 PC=%0d want=16", bus.PC); end
    endtask

    task automatic test_call_ret();
        bus.Call = 1'b1; bus.Target = 10'd40;
        step();
        clr();
        total++; if (bus.PC !== 10'd40) begin bad++; $display("FAIL call_pc PC=%0d want=40", bus.PC); end
        bus.Ret = 1'b1;
        step();
        total++; if (bus.PC !== 10'd17) begin bad++; $display("FAIL ret_pc PC=%0d want=17", bus.PC); end
        total++; if (bus.StackErr !== 1'b0) begin bad++; $display("FAIL ret_ok_err got=%b want=0", bus.StackErr); end
        step();
        clr();
        total++; if (bus.PC !== 10'd18) begin bad++; $display("FAIL ret_empty_pc PC=%0d want=18", bus.PC); end
        total++; if (bus.StackErr !== 1'b1) begin bad++; $display("FAIL ret_empty_err got=%b want=1", bus.StackErr); end
    endtask

    task automatic test_overflow();
        // Halt then restart clears the sticky error and the stack.
        bus.Halt = 1'b1;
        step();
        clr();
        total++; if (bus.Done !== 1'b1) begin bad++; $display("FAIL halt_done got=%b want=1", bus.Done); end
        bus.Start = 1'b1;
        step();
        clr();
        total++; if (bus.StackErr !== 1'b0) begin bad++; $display("FAIL restart_err got=%b want=0", bus.StackErr); end
        total++; if (bus.PC !== 10'd0) begin bad++; $display("FAIL restart_pc PC=%0d want=0", bus.PC); end
        for (int i = 1; i <= 5; i++) begin
            bus.Call = 1'b1; bus.Target = 10'(i * 100);
            step();
            total++; if (bus.PC !== 10'(i * 100)) begin bad++; $display("FAIL nest_call%0d PC=%0d want=%0d", i, bus.PC, i * 100); end
            total++; if (bus.StackErr !== (i == 5)) begin bad++; $display("FAIL nest_err%0d got=%b want=%b", i, bus.StackErr, (i == 5)); end
        end
        clr();
        // Pushed return addresses were 1,101,201,301; the fifth call was dropped.
        for (int i = 3; i >= 0; i--) begin
            bus.Ret = 1'b1;
            step();
            total++; if (bus.PC !== 10'(i * 100 + 1)) begin bad++; $display("FAIL unwind%0d PC=%0d want=%0d", i, bus.PC, i * 100 + 1); end
        end
        step();
        clr();
        total++; if (bus.PC !== 10'd2) begin bad++; $display("FAIL unwind_empty PC=%0d want=2", bus.PC); end
    endtask

    task automatic test_wrap_halt();
        bus.Branch = 1'b1; bus.Target = 10'd1023;
        step();
        clr();
        total++; if (bus.PC !== 10'd1023) begin bad++; $display("FAIL to_top PC=%0d want=1023", bus.PC); end
        step();
        total++; if (bus.PC !== 10'd0) begin bad++; $display("FAIL wrap PC=%0d want=0", bus.PC); end
        step();
        total++; if (bus.PC !== 10'd1) begin bad++; $display("FAIL post_wrap PC=%0d want=1", bus.PC); end
        bus.Halt = 1'b1;
        step();
        clr();
        total++; if (bus.PC !== 10'd1) begin bad++; $display("FAIL halt_pc PC=%0d want=1", bus.PC); end
        total++; if (bus.Done !== 1'b1 || bus.Running !== 1'b0) begin bad++; $display("FAIL halt_flags done=%b run=%b want=1,0", bus.Done, bus.Running); end
        bus.Branch = 1'b1; bus.Target = 10'd77; bus.Call = 1'b1;
        step();
        step();
        clr();
        total++; if (bus.PC !== 10'd1) begin bad++; $display("FAIL halted_frozen PC=%0d want=1", bus.PC); end
        bus.Start = 1'b1; bus.Halt = 1'b1;
        step();
        clr();
        total++; if (bus.PC !== 10'd0) begin bad++; $display("FAIL halted_start PC=%0d want=0", bus.PC); end
        total++; if (bus.Running !== 1'b1 || bus.Done !== 1'b0) begin bad++; $display("FAIL start_wins run=%b done=%b want=1,0", bus.Running, bus.Done); end
        total++; if (bus.StackErr !== 1'b0) begin bad++; $display("FAIL restart_clears_err got=%b want=0", bus.StackErr); end
    endtask

    task automatic test_run_controls();
        step();
        step();
        bus.Start = 1'b1;
        step();
        total++; if (bus.PC !== 10'd3) begin bad++; $display("FAIL start_in_run PC=%0d want=3", bus.PC); end
        bus.Halt = 1'b1;
        step();
        clr();
        total++; if (bus.PC !== 10'd3 || bus.Done !== 1'b1) begin bad++; $display("FAIL halt_wins PC=%0d done=%b want=3,1", bus.PC, bus.Done); end
        bus.Start = 1'b1;
        step();
        clr();
        total++; if (bus.PC !== 10'd0) begin bad++; $display("FAIL restart2 PC=%0d want=0", bus.PC); end
    endtask

    task automatic test_priority();
        bus.Call = 1'b1; bus.Target = 10'd50;
        step();
        total++; if (bus.PC !== 10'd50) begin bad++; $display("FAIL pri_call PC=%0d want=50", bus.PC); end
        bus.Ret = 1'b1; bus.Target = 10'd60;
        step();
        clr();
        total++; if (bus.PC !== 10'd1) begin bad++; $display("FAIL ret_over_call PC=%0d want=1", bus.PC); end
        bus.Call = 1'b1; bus.Branch = 1'b1; bus.Target = 10'd70;
        step();
        clr();
        total++; if (bus.PC !== 10'd70) begin bad++; $display("FAIL call_branch PC=%0d want=70", bus.PC); end
        bus.Ret = 1'b1;
        step();
        clr();
        total++; if (bus.PC !== 10'd2) begin bad++; $display("FAIL call_over_branch PC=%0d want=2", bus.PC); end
        total++; if (bus.StackErr !== 1'b0) begin bad++; $display("FAIL pri_err got=%b want=0", bus.StackErr); end
    endtask

    task automatic test_async_reset();
        bus.Call = 1'b1; bus.Target = 10'd90;
        step();
        clr();
        #2;
        init_n = 1'b0;
        #1;
        total++; if (bus.PC !== 10'd0 || bus.Running !== 1'b0) begin bad++; $display("FAIL async_reset PC=%0d run=%b want=0,0", bus.PC, bus.Running); end
        step();
        init_n = 1'b1;
        bus.Start = 1'b1;
        step();
        clr();
        bus.Ret = 1'b1;
        step();
        clr();
        total++; if (bus.PC !== 10'd1 || bus.StackErr !== 1'b1) begin bad++; $display("FAIL stack_lost PC=%0d err=%b want=1,1", bus.PC, bus.StackErr); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        init_n = 1'b0;
        clr();
        test_reset();
        test_start_abs();
        test_rel_branch();
        test_call_ret();
        test_overflow();
        test_wrap_halt();
        test_run_controls();
        test_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
